mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline latch outputs.
- Performs the data-memory load/store over a variable-latency req/ack handshake and stalls the upstream pipeline while the access is outstanding.
- Registers the results into the MEM/WB latch outputs that feed write-back.
- For non-memory instructions it behaves as a plain 1-cycle pipeline register.

Parameters:
- MAX_WAIT, 15: falling edges spent in WAIT without dm_ack before the access is aborted. Legal range 1..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on the falling edge, as for the other pipeline latches.
- rst  in  1  reset; asynchronous, active-low.
- MEM_WB  in  2  [1] RegWrite, [0] MemToReg.
- MEM_M  in  2  [1] MemRead, [0] MemWrite.
- MEM_ALU_Output  in  32  memory address, or ALU result for non-memory instructions.
- MEM_read_Rt  in  32  store data.
- MEM_Rd  in  5  write-back register address.
- dm_ack  in  1  data memory: access complete.
- dm_rdata  in  32  data memory: load data, valid when dm_ack=1.
- dm_req  out  1  data memory request, registered.
- dm_we  out  1  1=write, 0=read, registered.
- dm_addr  out  32  access address, registered.
- dm_wdata  out  32  store data, registered.
- stall  out  1  combinational; upstream holds its EX/MEM outputs stable while high.
- WB_WB  out  2  registered control to write-back.
- WB_read_data  out  32  load result.
- WB_ALU_Output  out  32  forwarded ALU result/address.
- WB_Rd  out  5  write-back register address.
- mem_err  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE; wait counter 0. dm_req drops immediately, including mid-access; the pending access is discarded.
- State IDLE, MEM_M=00, on falling edge:
  - WB_WB<=MEM_WB, WB_ALU_Output<=MEM_ALU_Output, WB_Rd<=MEM_Rd, WB_read_data<=0, mem_err<=0.
  - Latency 1 edge; stall=0.
- State IDLE, MEM_M!=00:
  - stall=1 combinationally in the same cycle.
  - On the edge: capture MEM_WB/MEM_Rd/MEM_ALU_Output internally; dm_req<=1; dm_addr<=MEM_ALU_Output; dm_wdata<=MEM_read_Rt; dm_we<=MEM_M[0] (MemWrite wins when MEM_M=11); counter<=0; go WAIT.
  - WB_WB<=00 (bubble).
- State WAIT, dm_ack=0:
  - stall=1.
  - Each edge: counter+1; WB_WB<=00.
- State WAIT, dm_ack=1:
  - stall=0 in this cycle, so upstream advances on the same edge.
  - On the edge: dm_req<=0; WB_WB<=captured WB; WB_ALU_Output<=captured address; WB_Rd<=captured Rd.
  - WB_read_data<=dm_rdata for a read, 0 for a write. Go IDLE.
- Timeout: in WAIT with dm_ack=0 and counter=MAX_WAIT-1:
  - stall=0 in that cycle.
  - On the edge: dm_req<=0; WB_WB<=00; mem_err<=1 for exactly one cycle; go IDLE.
  - An ack that arrives after the abort is ignored.
- dm_ack while IDLE is ignored.
- dm_addr, dm_wdata and dm_we hold their values while dm_req=1.
- Back-to-back memory ops: the second is accepted in the IDLE cycle after completion. Minimum 2 edges per access; no edge-to-edge overlap.
- WB_WB is 00 on every edge that does not retire an instruction. Write-back never sees a duplicate or stale write.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE with MEM_M!=00 and MEM_ALU_Output[1:0]!=00:
  - No request is issued and stall=0.
  - On the edge: WB_WB<=00, mem_err<=1 for one cycle; remain IDLE.
- Undefined: no check; dm_addr carries the unaligned address unchanged.

Test Plan:
1. Reset then ALU op (MEM_WB=10, MEM_M=00, ALU=0x0000_0011, Rd=5) -> next edge WB_WB=10, WB_ALU_Output=0x11, WB_Rd=5, stall never high.
2. Load: MEM_M=10, addr=0x40, MEM_WB=11, Rd=8; dm_ack asserted 3 edges after dm_req with dm_rdata=0xDEAD_BEEF -> dm_req=1/dm_we=0/dm_addr=0x40 during wait; stall high 3 cycles; WB_WB=00 meanwhile; then WB_WB=11, WB_read_data=0xDEADBEEF, WB_Rd=8.
3. Store: MEM_M=01, addr=0x44, Rt=0x1234_5678, ack after 1 edge -> dm_we=1, dm_wdata=0x12345678; WB_WB=MEM_WB; WB_read_data=0.
4. Timeout with MAX_WAIT=4, dm_ack tied 0 -> dm_req high exactly 4 edges; then dm_req=0, mem_err pulse 1 cycle, WB_WB=00; a late ack is ignored and no write-back occurs.
5. rst driven low mid-WAIT (between edges) -> dm_req, stall and all WB_* go 0 immediately; after release an ALU op passes with 1-edge latency.
6. With MEM_ALIGN_CHECK_EN: load to addr=0x42 -> no dm_req, mem_err=1 one cycle, WB_WB=00. Without it: dm_addr=0x42 and the normal handshake runs.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between the EX/MEM and MEM/WB latches.
// Issues data-memory loads/stores over a variable-latency req/ack handshake,
// holds the upstream pipeline while an access is outstanding, and aborts an
// access that waits MAX_WAIT edges without an acknowledge.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects word-misaligned accesses.
//
// Handshake: dm_req rises on the issue edge and stays high, with dm_addr,
// dm_wdata and dm_we held constant, until the falling edge on which dm_ack=1
// is sampled (completion) or the wait budget runs out (abort). An ack seen
// while no request is outstanding is ignored. Upstream holds its EX/MEM
// outputs while stall=1 and advances on any edge where stall=0.
// All state updates happen on the falling edge of clk.
module mem_access_stage #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MEM_WB,
   input  logic [1:0]  MEM_M,
   input  logic [31:0] MEM_ALU_Output,
   input  logic [31:0] MEM_read_Rt,
   input  logic [4:0]  MEM_Rd,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        stall,
   output logic [1:0]  WB_WB,
   output logic [31:0] WB_read_data,
   output logic [31:0] WB_ALU_Output,
   output logic [4:0]  WB_Rd,
   output logic        mem_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [1:0]        cap_wb_q;
   logic [4:0]        cap_rd_q;
   logic [31:0]       cap_alu_q;
   logic              cap_we_q;

   logic              dm_req_q;
   logic              dm_we_q;
   logic [31:0]       dm_addr_q;
   logic [31:0]       dm_wdata_q;
   logic [1:0]        wb_wb_q;
   logic [31:0]       wb_read_data_q;
   logic [31:0]       wb_alu_q;
   logic [4:0]        wb_rd_q;
   logic              mem_err_q;

   logic              mem_op;
   logic              misaligned;
   logic              timeout;
   logic              stall_c;

   assign mem_op = |MEM_M;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = mem_op && (MEM_ALU_Output[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   assign timeout = (state_q == S_WAIT) && !dm_ack && (cnt_q == LAST_CNT);
   assign cnt_d   = cnt_q + 1'b1;

   // Stall while a request is being issued or is waiting for its ack; an ack
   // or the final timeout cycle lets upstream advance on the same edge.
   always_comb begin
      stall_c = 1'b0;
      case (state_q)
         S_IDLE:  stall_c = mem_op && !misaligned;
         S_WAIT:  stall_c = !dm_ack && !timeout;
         default: stall_c = 1'b0;
      endcase
   end

   // Reset forces stall low immediately, even with a memory op presented.
   assign stall = rst & stall_c;

   // Stage FSM with registered memory-port and write-back outputs.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         cap_wb_q       <= 2'b00;
         cap_rd_q       <= 5'd0;
         cap_alu_q      <= 32'd0;
         cap_we_q       <= 1'b0;
         dm_req_q       <= 1'b0;
         dm_we_q        <= 1'b0;
         dm_addr_q      <= 32'd0;
         dm_wdata_q     <= 32'd0;
         wb_wb_q        <= 2'b00;
         wb_read_data_q <= 32'd0;
         wb_alu_q       <= 32'd0;
         wb_rd_q        <= 5'd0;
         mem_err_q      <= 1'b0;
      end else begin
         // Nothing retires unless a branch below says so.
         wb_wb_q   <= 2'b00;
         mem_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!mem_op) begin
                  wb_wb_q        <= MEM_WB;
                  wb_alu_q       <= MEM_ALU_Output;
                  wb_rd_q        <= MEM_Rd;
                  wb_read_data_q <= 32'd0;
               end else if (misaligned) begin
                  mem_err_q <= 1'b1;
               end else begin
                  cap_wb_q   <= MEM_WB;
                  cap_rd_q   <= MEM_Rd;
                  cap_alu_q  <= MEM_ALU_Output;
                  cap_we_q   <= MEM_M[0];
                  dm_req_q   <= 1'b1;
                  dm_we_q    <= MEM_M[0];
                  dm_addr_q  <= MEM_ALU_Output;
                  dm_wdata_q <= MEM_read_Rt;
                  cnt_q      <= '0;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dm_ack) begin
                  dm_req_q       <= 1'b0;
                  wb_wb_q        <= cap_wb_q;
                  wb_alu_q       <= cap_alu_q;
                  wb_rd_q        <= cap_rd_q;
                  wb_read_data_q <= cap_we_q ? 32'd0 : dm_rdata;
                  state_q        <= S_IDLE;
               end else if (timeout) begin
                  dm_req_q  <= 1'b0;
                  mem_err_q <= 1'b1;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dm_req        = dm_req_q;
   assign dm_we         = dm_we_q;
   assign dm_addr       = dm_addr_q;
   assign dm_wdata      = dm_wdata_q;
   assign WB_WB         = wb_wb_q;
   assign WB_read_data  = wb_read_data_q;
   assign WB_ALU_Output = wb_alu_q;
   assign WB_Rd         = wb_rd_q;
   assign mem_err       = mem_err_q;

endmodule
